uart_cmd_ctrl: RTL and testbench
================================

// Module: uart_cmd_ctrl
// PURPOSE
//  Frame sequencer behind the UART receiver. Consumes the byte stream (valid pulse + byte) and
//  hunts for command frames. Buffers the payload and checks an XOR checksum. Only after a good
//  checksum does it issue a burst of register writes over a valid/ready port.
//  Sits between uart_rx and the register file; no frame has any effect until it fully validates.
// PARAMETERS
//  CLKS_PER_BIT  435  i_Clock cycles per UART bit; base unit for the inter-byte timeout
//  TIMEOUT_BITS  20   max gap between bytes of one frame, in bit times
//  MAX_LEN       16   max payload bytes per frame (2..255)
// PORTS
//  i_Clock       in   1   system clock, all logic on posedge
//  i_Reset       in   1   asynchronous, active-high reset
//  i_Rx_DV       in   1   one-cycle pulse: i_Rx_Byte valid
//  i_Rx_Byte     in   8   received byte
//  o_Wr_Valid    out  1   register write request
//  o_Wr_Addr     out  8   write address
//  o_Wr_Data     out  8   write data
//  i_Wr_Ready    in   1   write accepted when o_Wr_Valid && i_Wr_Ready
//  o_Busy        out  1   high in any state other than S_SYNC
//  o_Frame_OK    out  1   one-cycle pulse: frame fully committed
//  o_Frame_Err   out  1   one-cycle pulse: frame discarded; cause in o_Err_Code
//  o_Err_Code    out  2   0 none, 1 bad checksum, 2 bad CMD/LEN, 3 timeout; held until next pulse
// BEHAVIOUR
//  Frame format: 0xA5, CMD(0x01 = write), ADDR, LEN(1..MAX_LEN), DATA[LEN], CHK.
//   CHK = XOR of CMD, ADDR, LEN and all DATA bytes.
//  Reset values: all outputs 0, state S_SYNC, timeout counter 0, buffer contents don't-care.
//  FSM states and transitions:
//   S_SYNC: ignore all bytes except 0xA5 -> S_CMD.
//   S_CMD:  CMD != 0x01 -> error 2.
//   S_ADDR: capture base address.
//   S_LEN:  LEN == 0 or LEN > MAX_LEN -> error 2.
//   S_DATA: store byte into buffer[idx]; after LEN bytes -> S_CHK.
//   S_CHK:  compare -> S_COMMIT, or error 1.
//   S_COMMIT: present buffer[k] at ADDR+k, k = 0..LEN-1. Address wraps modulo 256 (0xFF+1 = 0x00).
//    Next write is presented the cycle after the handshake, so at most 1 write per 2 clocks.
//    After the last handshake: o_Frame_OK pulses for 1 cycle -> S_SYNC.
//  Error path: o_Frame_Err pulses for 1 cycle, o_Err_Code is updated, FSM -> S_SYNC.
//   The offending byte is not re-examined as sync.
//  Checksum: running 8-bit XOR, cleared on entry to S_CMD.
//  Timeout: counter cleared on every i_Rx_DV and held at 0 in S_SYNC and S_COMMIT.
//   Reaching CLKS_PER_BIT*TIMEOUT_BITS-1 -> error 3.
//   Counter width = $clog2(CLKS_PER_BIT*TIMEOUT_BITS).
//  Handshake: o_Wr_Valid, o_Wr_Addr and o_Wr_Data stay stable until i_Wr_Ready. No timeout while stalled.
//  Bytes arriving in S_COMMIT are dropped, not buffered. The sender must wait for o_Frame_OK.
//  Timeout and i_Rx_DV in the same cycle: the byte wins and the counter clears.
//  Reset mid-frame or mid-commit: immediate abort. No further writes; no OK or Err pulse.
//  Latency: first o_Wr_Valid 2 cycles after the CHK byte's i_Rx_DV.
// STRUCTURE
//  Shared package uart_cmd_pkg: SYNC_BYTE, CMD_WRITE, ERR_* codes, state encodings.
//  Sub-module uart_cmd_buf: MAX_LEN x 8 register file, synchronous write and async read.
//   Indexed by a $clog2(MAX_LEN)-bit pointer; no reset on contents.
//  Top holds the FSM, checksum, timeout counter, commit address/index counters and status registers.
// TESTING
//  1. A5 01 10 02 AB CD (CHK=0x75), ready tied high
//     -> writes (0x10,0xAB), (0x11,0xCD); one o_Frame_OK pulse.
//  2. Same frame with CHK=0x00 -> no writes; o_Frame_Err pulse, o_Err_Code=1.
//  3. Bytes 00 FF then A5 02 -> garbage ignored; CMD 0x02 gives o_Err_Code=2.
//     Also LEN=0 and LEN=MAX_LEN+1 each give code 2.
//  4. A5 01 10, then silence > CLKS_PER_BIT*TIMEOUT_BITS cycles -> o_Err_Code=3, o_Busy low.
//  5. ADDR=0xFF, LEN=3, i_Wr_Ready low 5 cycles on each write
//     -> addresses FF, 00, 01; signals stable while stalled; one OK pulse.
//  6. Assert i_Reset during S_DATA and again during S_COMMIT
//     -> all outputs 0 at once; next valid frame processes normally.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART command frame sequencer: frame bytes,
// error codes and FSM state encodings.
package uart_cmd_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] CMD_WRITE = 8'h01;

    typedef logic [1:0] err_code_t;
    localparam err_code_t ERR_NONE     = 2'd0;
    localparam err_code_t ERR_CHECKSUM = 2'd1;
    localparam err_code_t ERR_CMD_LEN  = 2'd2;
    localparam err_code_t ERR_TIMEOUT  = 2'd3;

    typedef logic [2:0] state_t;
    localparam state_t S_SYNC   = 3'd0;
    localparam state_t S_CMD    = 3'd1;
    localparam state_t S_ADDR   = 3'd2;
    localparam state_t S_LEN    = 3'd3;
    localparam state_t S_DATA   = 3'd4;
    localparam state_t S_CHK    = 3'd5;
    localparam state_t S_COMMIT = 3'd6;

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Byte stream in, register-write port out, plus frame status.
// master: the frame controller; slave: the surrounding system.
interface uart_cmd_ctrl_if;

    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       wr_valid;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       busy;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;

    modport master (
        input  rx_dv, rx_byte, wr_ready,
        output wr_valid, wr_addr, wr_data, busy, frame_ok, frame_err, err_code
    );

    modport slave (
        output rx_dv, rx_byte, wr_ready,
        input  wr_valid, wr_addr, wr_data, busy, frame_ok, frame_err, err_code
    );

endinterface

// File: rtl/uart_cmd_buf.sv
// Payload buffer: small register file, synchronous write, asynchronous read.
// Contents are not reset; every entry read back was written by the current frame.
module uart_cmd_buf #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned PTR_W = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] wr_ptr,
    input  logic [7:0]       wr_data,
    input  logic [PTR_W-1:0] rd_ptr,
    output logic [7:0]       rd_data
);

    logic [7:0] mem [DEPTH];

    // Store one payload byte per write strobe
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Frame sequencer behind the UART receiver. Hunts for A5-framed write
// commands, buffers the payload, verifies the XOR checksum and only then
// replays the payload as a burst of register writes.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 435,
    parameter int unsigned TIMEOUT_BITS = 20,
    parameter int unsigned MAX_LEN      = 16
) (
    input  logic            clk,
    input  logic            rst,
    uart_cmd_ctrl_if.master bus
);

    localparam int unsigned      TMO_CYCLES = CLKS_PER_BIT * TIMEOUT_BITS;
    localparam int unsigned      TMO_W      = $clog2(TMO_CYCLES);
    localparam logic [TMO_W-1:0] TMO_MAX    = TMO_W'(TMO_CYCLES - 1);
    localparam int unsigned      PTR_W      = $clog2(MAX_LEN);
    localparam logic [7:0]       MAX_LEN_B  = 8'(MAX_LEN);

    state_t           state_q, state_d;
    logic [7:0]       chk_q, chk_d;
    logic [7:0]       base_q, base_d;
    logic [7:0]       len_q, len_d;
    logic [PTR_W-1:0] idx_q, idx_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             wr_valid_q, wr_valid_d;
    logic [7:0]       wr_addr_q, wr_addr_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic             ok_q, ok_d;
    logic             err_q, err_d;
    err_code_t        code_q, code_d;

    logic             buf_we;
    logic [7:0]       buf_rd_data;
    logic [7:0]       idx_ext;
    logic             last_idx;
    logic             tmo_run;
    logic             fail;
    err_code_t        fail_code;

    uart_cmd_buf #(
        .DEPTH (MAX_LEN),
        .PTR_W (PTR_W)
    ) u_buf (
        .clk     (clk),
        .we      (buf_we),
        .wr_ptr  (idx_q),
        .wr_data (bus.rx_byte),
        .rd_ptr  (idx_q),
        .rd_data (buf_rd_data)
    );

    assign idx_ext  = 8'(idx_q);
    assign last_idx = (idx_ext == len_q - 8'd1);
    // The timeout only runs while a frame is being received
    assign tmo_run  = (state_q != S_SYNC) && (state_q != S_COMMIT);

    // Next-state logic: frame parsing, checksum, timeout and write sequencing
    always_comb begin
        state_d    = state_q;
        chk_d      = chk_q;
        base_d     = base_q;
        len_d      = len_q;
        idx_d      = idx_q;
        wr_valid_d = wr_valid_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        code_d     = code_q;
        ok_d       = 1'b0;
        err_d      = 1'b0;
        buf_we     = 1'b0;
        fail       = 1'b0;
        fail_code  = ERR_NONE;

        // A byte in the expiring cycle wins: rx_dv clears and suppresses the timeout
        tmo_d = (bus.rx_dv || !tmo_run) ? '0 : tmo_q + 1'b1;
        if (tmo_run && !bus.rx_dv && (tmo_q == TMO_MAX)) begin
            fail      = 1'b1;
            fail_code = ERR_TIMEOUT;
        end

        unique case (state_q)
            S_SYNC: begin
                if (bus.rx_dv && (bus.rx_byte == SYNC_BYTE)) begin
                    chk_d   = '0;
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                if (bus.rx_dv) begin
                    if (bus.rx_byte == CMD_WRITE) begin
                        chk_d   = chk_q ^ bus.rx_byte;
                        state_d = S_ADDR;
                    end else begin
                        fail      = 1'b1;
                        fail_code = ERR_CMD_LEN;
                    end
                end
            end
            S_ADDR: begin
                if (bus.rx_dv) begin
                    base_d  = bus.rx_byte;
                    chk_d   = chk_q ^ bus.rx_byte;
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (bus.rx_dv) begin
                    if ((bus.rx_byte == 8'd0) || (bus.rx_byte > MAX_LEN_B)) begin
                        fail      = 1'b1;
                        fail_code = ERR_CMD_LEN;
                    end else begin
                        len_d   = bus.rx_byte;
                        chk_d   = chk_q ^ bus.rx_byte;
                        idx_d   = '0;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (bus.rx_dv) begin
                    buf_we = 1'b1;
                    chk_d  = chk_q ^ bus.rx_byte;
                    if (last_idx) begin
                        idx_d   = '0;
                        state_d = S_CHK;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_CHK: begin
                if (bus.rx_dv) begin
                    if (bus.rx_byte == chk_q) begin
                        idx_d   = '0;
                        state_d = S_COMMIT;
                    end else begin
                        fail      = 1'b1;
                        fail_code = ERR_CHECKSUM;
                    end
                end
            end
            S_COMMIT: begin
                // Present, hold until accepted, then drop valid for one cycle
                if (wr_valid_q) begin
                    if (bus.wr_ready) begin
                        wr_valid_d = 1'b0;
                        if (last_idx) begin
                            ok_d    = 1'b1;
                            code_d  = ERR_NONE;
                            state_d = S_SYNC;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end else begin
                    wr_valid_d = 1'b1;
                    wr_addr_d  = base_q + idx_ext;
                    wr_data_d  = buf_rd_data;
                end
            end
            default: begin
                state_d = S_SYNC;
            end
        endcase

        if (fail) begin
            err_d   = 1'b1;
            code_d  = fail_code;
            tmo_d   = '0;
            state_d = S_SYNC;
        end
    end

    // State and output registers; reset aborts any frame or burst immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_SYNC;
            chk_q      <= '0;
            base_q     <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            tmo_q      <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
            code_q     <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            chk_q      <= chk_d;
            base_q     <= base_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            tmo_q      <= tmo_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
            code_q     <= code_d;
        end
    end

    assign bus.wr_valid  = wr_valid_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.busy      = (state_q != S_SYNC);
    assign bus.frame_ok  = ok_q;
    assign bus.frame_err = err_q;
    assign bus.err_code  = code_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: expected writes are queued as frames
// are sent and popped as the DUT completes write handshakes.
module tb_uart_cmd_ctrl;
    import uart_cmd_pkg::*;

    localparam int unsigned CPB  = 4;
    localparam int unsigned TOB  = 20;
    localparam int unsigned MAXL = 16;
    localparam int          TMO  = CPB * TOB;

    logic clk = 1'b0;
    logic rst;

    uart_cmd_ctrl_if bus ();

    uart_cmd_ctrl #(
        .CLKS_PER_BIT (CPB),
        .TIMEOUT_BITS (TOB),
        .MAX_LEN      (MAXL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  pay[$];
    int          ok_cnt = 0;
    int          err_cnt = 0;
    logic [1:0]  last_code = 2'd0;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic        prev_hs = 1'b0;
    logic [7:0]  prev_addr = 8'd0;
    logic [7:0]  prev_data = 8'd0;

    // Monitor: pulse counters, write scoreboard, stall stability, write spacing
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            logic [15:0] exp_wr;
            if (bus.frame_ok) ok_cnt++;
            if (bus.frame_err) begin
                err_cnt++;
                last_code = bus.err_code;
            end
            if (prev_valid && !prev_ready) begin
                checks++;
                if (!bus.wr_valid || bus.wr_addr !== prev_addr || bus.wr_data !== prev_data) begin
                    errors++;
                    $display("FAIL stall_stable: got v=%0b %h/%h, want v=1 %h/%h",
                             bus.wr_valid, bus.wr_addr, bus.wr_data, prev_addr, prev_data);
                end
            end
            if (prev_hs) begin
                checks++;
                if (bus.wr_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL write_gap: wr_valid=%b right after handshake, want 0",
                             bus.wr_valid);
                end
            end
            if (bus.wr_valid && bus.wr_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got %h/%h, want no write",
                             bus.wr_addr, bus.wr_data);
                end else begin
                    exp_wr = exp_q.pop_front();
                    if ({bus.wr_addr, bus.wr_data} !== exp_wr) begin
                        errors++;
                        $display("FAIL write_data: got %h/%h, want %h/%h",
                                 bus.wr_addr, bus.wr_data, exp_wr[15:8], exp_wr[7:0]);
                    end
                end
            end
            prev_valid = bus.wr_valid;
            prev_ready = bus.wr_ready;
            prev_addr  = bus.wr_addr;
            prev_data  = bus.wr_data;
            prev_hs    = bus.wr_valid && bus.wr_ready;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(posedge clk);
        @(posedge clk);
        #1;
        bus.rx_dv   = 1'b1;
        bus.rx_byte = b;
        @(posedge clk);
        #1;
        bus.rx_dv = 1'b0;
    endtask

    // Sends A5 01 addr len pay... chk; queues the expected writes if asked
    task automatic send_frame(input logic [7:0] addr, input bit bad_chk, input bit expect_wr,
                              input int gap);
        logic [7:0] len;
        logic [7:0] chk;
        len = 8'(pay.size());
        chk = CMD_WRITE ^ addr ^ len;
        for (int i = 0; i < pay.size(); i++) chk ^= pay[i];
        if (expect_wr) begin
            for (int i = 0; i < pay.size(); i++) exp_q.push_back({addr + 8'(i), pay[i]});
        end
        send_byte(SYNC_BYTE, gap);
        send_byte(CMD_WRITE, gap);
        send_byte(addr, gap);
        send_byte(len, gap);
        for (int i = 0; i < pay.size(); i++) send_byte(pay[i], gap);
        send_byte(bad_chk ? 8'h00 : chk, gap);
    endtask

    task automatic wait_frame_end(input int start, input string tag);
        int n = 0;
        while ((ok_cnt + err_cnt) == start && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if ((ok_cnt + err_cnt) == start) begin
            errors++;
            $display("FAIL %s_end: no OK/Err pulse after %0d cycles, want one", tag, n);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic expect_counts(input int ok0, input int err0, input int dok, input int derr,
                                 input string tag);
        checks++;
        if (ok_cnt - ok0 != dok || err_cnt - err0 != derr) begin
            errors++;
            $display("FAIL %s_pulses: got ok+%0d err+%0d, want ok+%0d err+%0d",
                     tag, ok_cnt - ok0, err_cnt - err0, dok, derr);
        end
        checks++;
        if (exp_q.size() != 0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: got pending=%0d busy=%b, want 0 0",
                     tag, exp_q.size(), bus.busy);
        end
    endtask

    task automatic expect_code(input logic [1:0] want, input string tag);
        checks++;
        if (last_code !== want || bus.err_code !== want) begin
            errors++;
            $display("FAIL %s_code: got pulse=%0d held=%0d, want %0d",
                     tag, last_code, bus.err_code, want);
        end
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({bus.wr_valid, bus.wr_addr, bus.wr_data, bus.busy, bus.frame_ok, bus.frame_err,
             bus.err_code} !== 22'd0) begin
            errors++;
            $display("FAIL %s_outputs: got v=%b a=%h d=%h busy=%b ok=%b err=%b code=%0d, want all 0",
                     tag, bus.wr_valid, bus.wr_addr, bus.wr_data, bus.busy, bus.frame_ok,
                     bus.frame_err, bus.err_code);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("after_reset");
    endtask

    task automatic test_basic();
        int ok0 = ok_cnt;
        int err0 = err_cnt;
        pay = '{8'hAB, 8'hCD};
        send_frame(8'h10, 1'b0, 1'b1, 0);
        @(negedge clk);
        checks++;
        if (bus.wr_valid !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL latency_early: got v=%b busy=%b, want 0 1", bus.wr_valid, bus.busy);
        end
        @(negedge clk);
        checks++;
        if (bus.wr_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency_first: got v=%b two cycles after CHK, want 1", bus.wr_valid);
        end
        wait_frame_end(ok0 + err0, "basic");
        expect_counts(ok0, err0, 1, 0, "basic");
    endtask

    task automatic test_bad_checksum();
        int ok0 = ok_cnt;
        int err0 = err_cnt;
        pay = '{8'hAB, 8'hCD};
        send_frame(8'h10, 1'b1, 1'b0, 0);
        wait_frame_end(ok0 + err0, "bad_chk");
        expect_counts(ok0, err0, 0, 1, "bad_chk");
        expect_code(ERR_CHECKSUM, "bad_chk");
    endtask

    task automatic test_bad_cmd_len();
        int ok0 = ok_cnt;
        int err0 = err_cnt;
        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL garbage_busy: got busy=%b, want 0", bus.busy);
        end
        send_byte(SYNC_BYTE, 0);
        send_byte(8'h02, 0);
        wait_frame_end(ok0 + err0, "bad_cmd");
        expect_counts(ok0, err0, 0, 1, "bad_cmd");
        expect_code(ERR_CMD_LEN, "bad_cmd");
        for (int k = 0; k < 2; k++) begin
            ok0  = ok_cnt;
            err0 = err_cnt;
            send_byte(SYNC_BYTE, 0);
            send_byte(CMD_WRITE, 0);
            send_byte(8'h10, 0);
            send_byte((k == 0) ? 8'd0 : 8'(MAXL + 1), 0);
            wait_frame_end(ok0 + err0, "bad_len");
            expect_counts(ok0, err0, 0, 1, "bad_len");
            expect_code(ERR_CMD_LEN, "bad_len");
        end
    endtask

    task automatic test_max_len();
        int ok0 = ok_cnt;
        int err0 = err_cnt;
        pay.delete();
        for (int i = 0; i < MAXL; i++) pay.push_back(8'(i * 7 + 3));
        send_frame(8'hF8, 1'b0, 1'b1, 0);
        wait_frame_end(ok0 + err0, "max_len");
        expect_counts(ok0, err0, 1, 0, "max_len");
    endtask

    task automatic test_timeout();
        int ok0 = ok_cnt;
        int err0 = err_cnt;
        int n = 0;
        // Gaps just under the limit must not time out
        pay = '{8'h5A, 8'h3C};
        send_frame(8'h40, 1'b0, 1'b1, TMO - 10);
        wait_frame_end(ok0 + err0, "slow");
        expect_counts(ok0, err0, 1, 0, "slow");
        ok0  = ok_cnt;
        err0 = err_cnt;
        send_byte(SYNC_BYTE, 0);
        send_byte(CMD_WRITE, 0);
        send_byte(8'h10, 0);
        while (err_cnt == err0 && n < TMO + 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (n < TMO - 2 || n > TMO + 3) begin
            errors++;
            $display("FAIL timeout_time: got error after %0d cycles, want about %0d", n, TMO);
        end
        repeat (2) @(negedge clk);
        expect_counts(ok0, err0, 0, 1, "timeout");
        expect_code(ERR_TIMEOUT, "timeout");
    endtask

    task automatic test_reset_mid();
        int ok0;
        int err0;
        int n = 0;
        pay = '{8'hAA, 8'hBB, 8'hCC};
        send_byte(SYNC_BYTE, 0);
        send_byte(CMD_WRITE, 0);
        send_byte(8'h20, 0);
        send_byte(8'd3, 0);
        send_byte(8'hAA, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_all_zero("rst_data");
        @(posedge clk);
        #1;
        rst = 1'b0;
        // Reset during a stalled commit
        bus.wr_ready = 1'b0;
        send_frame(8'h30, 1'b0, 1'b1, 0);
        while (!bus.wr_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.wr_valid !== 1'b1) begin
            errors++;
            $display("FAIL commit_start: got wr_valid=%b, want 1", bus.wr_valid);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_all_zero("rst_commit");
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.wr_ready = 1'b1;
        ok0  = ok_cnt;
        err0 = err_cnt;
        repeat (10) @(negedge clk);
        expect_counts(ok0, err0, 0, 0, "rst_quiet");
        pay = '{8'h01, 8'h02};
        send_frame(8'h50, 1'b0, 1'b1, 1);
        wait_frame_end(ok0 + err0, "rst_next");
        expect_counts(ok0, err0, 1, 0, "rst_next");
    endtask

    task automatic test_wrap_stall();
        int ok0 = ok_cnt;
        int err0 = err_cnt;
        pay = '{8'h11, 8'h22, 8'h33};
        bus.wr_ready = 1'b0;
        send_frame(8'hFF, 1'b0, 1'b1, 0);
        for (int k = 0; k < 3; k++) begin
            int n = 0;
            while (!bus.wr_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (bus.wr_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_present: write %0d got wr_valid=%b, want 1", k, bus.wr_valid);
            end
            repeat (5) @(posedge clk);
            #1;
            bus.wr_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.wr_ready = 1'b0;
        end
        wait_frame_end(ok0 + err0, "wrap");
        expect_counts(ok0, err0, 1, 0, "wrap");
        bus.wr_ready = 1'b1;
    endtask

    initial begin
        bus.rx_dv    = 1'b0;
        bus.rx_byte  = 8'h00;
        bus.wr_ready = 1'b1;
        test_reset();
        test_basic();
        test_bad_checksum();
        test_bad_cmd_len();
        test_max_len();
        test_timeout();
        test_reset_mid();
        test_wrap_stall();
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
